gray_ptr_counter: RTL and testbench

Parametrised FIFO pointer generator for one clock domain of the asynchronous FIFO. It holds the local binary pointer and its registered Gray image, and accepts increment requests. It compares the local pointer against the already-synchronised opposite-domain Gray pointer to produce the full flag (write side) or the empty flag (read side), plus a registered occupancy level and an almost flag.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/gray2binary.sv | 14 +
 rtl/gray_ptr_counter.sv | 83 ++++++++
 tb/tb_gray_ptr_counter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the async FIFO pointer logic: side selection and
// pointer width (one extra bit beyond the address for full/empty wrap detection).
package fifo_pkg;

  localparam int MODE_WRITE = 0;
  localparam int MODE_READ  = 1;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/gray2binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2binary #(
  parameter int W = 6
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[W-1:gi];
  end

endmodule

// File: rtl/gray_ptr_counter.sv
// One clock domain's FIFO pointer: binary/Gray pointer pair, full or empty flag
// against the synchronised opposite pointer, plus registered level and almost flag.
module gray_ptr_counter
  import fifo_pkg::*;
#(
  parameter int Addr_width = 5,
  parameter int MODE       = MODE_WRITE,
  parameter int ALMOST_TH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Inc_en,
  input  logic [Addr_width:0]   Sync_gray_ptr,
  output logic                  Accept,
  output logic [Addr_width-1:0] Address,
  output logic [Addr_width:0]   Gray_pointer,
  output logic                  Flag,
  output logic                  Almost_flag,
  output logic [Addr_width:0]   Level
);

  localparam int PW    = ptr_w(Addr_width);
  localparam int DEPTH = 1 << Addr_width;

  // Full when the opposite pointer is exactly one lap behind: in Gray code
  // that means the top two bits inverted and the rest equal.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] TH_LO     = PW'(ALMOST_TH);
  localparam logic [PW-1:0] TH_HI     = PW'(DEPTH - ALMOST_TH);
  localparam logic          FLAG_RST  = (MODE == MODE_READ);
  localparam logic          ALM_RST   = (MODE == MODE_READ) || (ALMOST_TH == DEPTH);

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] sync_bin;
  logic          flag_q, flag_d;
  logic          almost_q, almost_d;

  gray2binary #(.W(PW)) u_sync_g2b (
    .gray_i (Sync_gray_ptr),
    .bin_o  (sync_bin)
  );

  assign Accept = Inc_en & ~flag_q;

  always_comb begin
    bin_d  = bin_q + PW'(Accept);
    gray_d = bin_d ^ (bin_d >> 1);
    if (MODE == MODE_READ) begin
      level_d  = sync_bin - bin_d;
      flag_d   = (gray_d == Sync_gray_ptr);
      almost_d = (level_d <= TH_LO);
    end else begin
      level_d  = bin_d - sync_bin;
      flag_d   = (gray_d == (Sync_gray_ptr ^ FULL_MASK));
      almost_d = (level_d >= TH_HI);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_q    <= '0;
      gray_q   <= '0;
      level_q  <= '0;
      flag_q   <= FLAG_RST;
      almost_q <= ALM_RST;
    end else begin
      bin_q    <= bin_d;
      gray_q   <= gray_d;
      level_q  <= level_d;
      flag_q   <= flag_d;
      almost_q <= almost_d;
    end
  end

  assign Address      = bin_q[Addr_width-1:0];
  assign Gray_pointer = gray_q;
  assign Flag         = flag_q;
  assign Almost_flag  = almost_q;
  assign Level        = level_q;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Scoreboard bench: write-side and read-side instances (depth 4, almost threshold 1)
// driven with directed vectors; a monitor pops expected snapshots after each edge.
module tb_gray_ptr_counter;

  logic       CLK, RST;
  logic       inc0, inc1;
  logic [2:0] sync0, sync1;
  logic       acc0, acc1, flag0, flag1, alm0, alm1;
  logic [1:0] addr0, addr1;
  logic [2:0] gray0, gray1, lvl0, lvl1;

  gray_ptr_counter #(.Addr_width(2), .MODE(0), .ALMOST_TH(1)) u_wr (
    .CLK(CLK), .RST(RST), .Inc_en(inc0), .Sync_gray_ptr(sync0), .Accept(acc0),
    .Address(addr0), .Gray_pointer(gray0), .Flag(flag0), .Almost_flag(alm0), .Level(lvl0)
  );

  gray_ptr_counter #(.Addr_width(2), .MODE(1), .ALMOST_TH(1)) u_rd (
    .CLK(CLK), .RST(RST), .Inc_en(inc1), .Sync_gray_ptr(sync1), .Accept(acc1),
    .Address(addr1), .Gray_pointer(gray1), .Flag(flag1), .Almost_flag(alm1), .Level(lvl1)
  );

  typedef struct {
    int          dut;
    string       nm;
    logic [10:0] exp;
  } rec_t;

  rec_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] GT [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed snapshot: {accept, address, gray, flag, almost, level}
  function automatic logic [10:0] pk(logic a, logic [1:0] ad, logic [2:0] g,
                                     logic f, logic al, logic [2:0] l);
    return {a, ad, g, f, al, l};
  endfunction

  task automatic check(string nm, logic [10:0] act, logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got acc/addr/gray/flag/alm/lvl=%b want %b", nm, act, exp);
    end
  endtask

  task automatic drive(int d, logic inc, logic [2:0] sync, string nm, logic [10:0] exp);
    @(negedge CLK);
    #1;
    if (d == 0) begin
      inc0 = inc; sync0 = sync;
    end else begin
      inc1 = inc; sync1 = sync;
    end
    q.push_back('{dut: d, nm: nm, exp: exp});
  endtask

  // Monitor: Accept sampled mid-low-phase, registers sampled just after the edge.
  initial begin
    logic a0s, a1s;
    rec_t r;
    forever begin
      @(negedge CLK);
      #3;
      a0s = acc0;
      a1s = acc1;
      @(posedge CLK);
      #1;
      while (q.size() > 0) begin
        r = q.pop_front();
        if (r.dut == 0) check(r.nm, {a0s, addr0, gray0, flag0, alm0, lvl0}, r.exp);
        else            check(r.nm, {a1s, addr1, gray1, flag1, alm1, lvl1}, r.exp);
      end
    end
  end

  initial begin
    int k;
    RST = 1'b0; inc0 = 1'b0; inc1 = 1'b0; sync0 = 3'b000; sync1 = 3'b000;
    #3 RST = 1'b1;
    #1;
    check("rst_wr_async", {acc0, addr0, gray0, flag0, alm0, lvl0}, pk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd0));
    check("rst_rd_async", {acc1, addr1, gray1, flag1, alm1, lvl1}, pk(1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 3'd0));
    @(negedge CLK);
    #1 RST = 1'b0;

    // write side fills with Sync at 000
    drive(0, 1'b1, 3'b000, "wr_acc1",      pk(1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 3'd1));
    drive(0, 1'b1, 3'b000, "wr_acc2",      pk(1'b1, 2'b10, 3'b011, 1'b0, 1'b0, 3'd2));
    drive(0, 1'b1, 3'b000, "wr_acc3_alm",  pk(1'b1, 2'b11, 3'b010, 1'b0, 1'b1, 3'd3));
    drive(0, 1'b1, 3'b000, "wr_acc4_full", pk(1'b1, 2'b00, 3'b110, 1'b1, 1'b1, 3'd4));
    drive(0, 1'b1, 3'b000, "wr_blocked",   pk(1'b0, 2'b00, 3'b110, 1'b1, 1'b1, 3'd4));
    drive(0, 1'b0, 3'b001, "wr_release",   pk(1'b0, 2'b00, 3'b110, 1'b0, 1'b1, 3'd3));
    drive(0, 1'b1, 3'b001, "wr_refill",    pk(1'b1, 2'b01, 3'b111, 1'b1, 1'b1, 3'd4));
    drive(0, 1'b1, 3'b011, "wr_simul",     pk(1'b0, 2'b01, 3'b111, 1'b0, 1'b1, 3'd3));
    drive(0, 1'b1, 3'b011, "wr_simul_acc", pk(1'b1, 2'b10, 3'b101, 1'b1, 1'b1, 3'd4));
    drive(0, 1'b1, 3'b011, "wr_hold_full", pk(1'b0, 2'b10, 3'b101, 1'b1, 1'b1, 3'd4));

    // mid-burst asynchronous reset with requests still asserted
    @(posedge CLK);
    #3 inc1 = 1'b1;
    RST = 1'b1;
    #1;
    check("rst_wr_mid", {acc0, addr0, gray0, flag0, alm0, lvl0}, pk(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 3'd0));
    check("rst_rd_mid", {acc1, addr1, gray1, flag1, alm1, lvl1}, pk(1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 3'd0));
    @(posedge CLK);
    #1;
    check("rst_wr_hold", {acc0, addr0, gray0, flag0, alm0, lvl0}, pk(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 3'd0));
    @(negedge CLK);
    #1 inc0 = 1'b0; inc1 = 1'b0; sync0 = 3'b000;
    RST = 1'b0;

    // read side: three entries appear, then drain
    drive(1, 1'b0, 3'b010, "rd_sync3",    pk(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 3'd3));
    drive(1, 1'b1, 3'b010, "rd_acc1",     pk(1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 3'd2));
    drive(1, 1'b1, 3'b010, "rd_acc2_alm", pk(1'b1, 2'b10, 3'b011, 1'b0, 1'b1, 3'd1));
    drive(1, 1'b1, 3'b010, "rd_acc3_emp", pk(1'b1, 2'b11, 3'b010, 1'b1, 1'b1, 3'd0));
    drive(1, 1'b1, 3'b010, "rd_blocked",  pk(1'b0, 2'b11, 3'b010, 1'b1, 1'b1, 3'd0));

    @(negedge CLK);
    #1 inc1 = 1'b0; sync1 = 3'b000;
    RST = 1'b1;
    #1;
    check("rst_rd_again", {acc1, addr1, gray1, flag1, alm1, lvl1}, pk(1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 3'd0));
    @(negedge CLK);
    #1 RST = 1'b0;

    // wrap: two rounds of 4 mirrored writes then 4 reads
    for (int r = 0; r < 2; r++) begin
      for (int j = 1; j <= 4; j++) begin
        k = 4 * r + j;
        drive(1, 1'b0, GT[k % 8], "wrap_wr",
              pk(1'b0, 2'b00, GT[4 * r], 1'b0, (j <= 1), 3'(j)));
      end
      for (int j = 1; j <= 4; j++) begin
        k = 4 * r + j;
        drive(1, 1'b1, GT[(4 * r + 4) % 8], "wrap_rd",
              pk(1'b1, 2'(k % 4), GT[k % 8], (j == 4), ((4 - j) <= 1), 3'(4 - j)));
      end
    end

    repeat (2) @(posedge CLK);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
